// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the WB stage
// and the multiply/divide unit. MDU results wait in a small FIFO and are written
// when WB leaves the port free. If WB keeps the port busy for too long, the
// pipeline is stalled for one cycle. A pending-register scoreboard drives the
// decode RAW interlock.
// Optional build macro: REGFILE_WB_BYPASS_EN. It adds byp_rs_hit, byp_rt_hit and
// byp_data, and removes the write-window term from raw_stall.
// Handshake: an MDU result transfers on a rising edge where mdu_valid && mdu_ready.
// mdu_valid, mdu_waddr and mdu_wdata stay stable until that edge. While pipe_stall
// is 1, the WB stage holds pipe_wen, pipe_waddr and pipe_wdata, and that write
// is not taken.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wen,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_stall,
  input  logic              mdu_issue,
  input  logic [ADDR_W-1:0] mdu_issue_addr,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_waddr,
  input  logic [DATA_W-1:0] mdu_wdata,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              raw_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              sb_err,
`ifdef REGFILE_WB_BYPASS_EN
  output logic              byp_rs_hit,
  output logic              byp_rt_hit,
  output logic [DATA_W-1:0] byp_data,
`endif
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DEFER = 2'd1;
  localparam logic [1:0] FORCE = 2'd2;

  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STARVE_LIMIT - 1);

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count, count_nxt;
  logic [NREG-1:0]   pending, pending_nxt;
  logic              push, pop, grant_pipe, last_entry, sb_err_nxt;
  logic              wr_we;
  logic [ADDR_W-1:0] wr_addr, head_addr;
  logic [DATA_W-1:0] wr_data, head_data;
  logic              raw_src, win_rs, win_rt;

  assign push       = mdu_valid && mdu_ready;
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  assign last_entry = (count == ONE_CNT) && !push;
  assign dbg_state  = state;

  // Arbitration: choose the write source, the next state and the starve count.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    grant_pipe     = 1'b0;
    pop            = 1'b0;
    case (state)
      IDLE: begin
        grant_pipe     = pipe_wen;
        starve_cnt_nxt = '0;
        if (push) state_nxt = DEFER;
      end
      DEFER: begin
        if (pipe_wen) begin
          grant_pipe     = 1'b1;
          starve_cnt_nxt = starve_cnt + 1'b1;
          if (starve_cnt_nxt == LAST_CNT) state_nxt = FORCE;
        end else begin
          pop            = 1'b1;
          starve_cnt_nxt = '0;
          if (last_entry) state_nxt = IDLE;
        end
      end
      FORCE: begin
        pop            = 1'b1;
        starve_cnt_nxt = '0;
        state_nxt      = last_entry ? IDLE : DEFER;
      end
      default: begin
        state_nxt      = IDLE;
        starve_cnt_nxt = '0;
      end
    endcase
  end

  // Next write-port value. Address 0 is never written.
  always_comb begin
    wr_we   = 1'b0;
    wr_addr = pipe_waddr;
    wr_data = pipe_wdata;
    if (grant_pipe) begin
      wr_we = (pipe_waddr != '0);
    end else if (pop) begin
      wr_addr = head_addr;
      wr_data = head_data;
      wr_we   = (head_addr != '0);
    end
  end

  // Scoreboard update. A set beats a clear of the same register in the same cycle.
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head_addr] = 1'b0;
    if (mdu_issue && (mdu_issue_addr != '0)) pending_nxt[mdu_issue_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
    sb_err_nxt = sb_err
               | (mdu_issue && (mdu_issue_addr != '0) && pending[mdu_issue_addr])
               | (push && !pending[mdu_waddr]);
    count_nxt = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end

  // Control state, FIFO pointers, scoreboard and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pending    <= '0;
      sb_err     <= 1'b0;
      mdu_ready  <= 1'b1;
      pipe_stall <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      count      <= count_nxt;
      pending    <= pending_nxt;
      sb_err     <= sb_err_nxt;
      mdu_ready  <= (count_nxt != FULL_CNT);
      pipe_stall <= (state_nxt == FORCE);
      rf_we      <= wr_we;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (grant_pipe || pop) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
    end
  end

  // FIFO storage. This is data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mdu_waddr;
      fifo_data[wr_ptr] <= mdu_wdata;
    end
  end

  // RAW interlock: pending sources plus the cycle in which the write is still in flight.
  always_comb begin
    raw_src = ((rs_addr != '0) && pending[rs_addr]) || ((rt_addr != '0) && pending[rt_addr]);
    win_rs  = rf_we && (rf_waddr != '0) && (rf_waddr == rs_addr);
    win_rt  = rf_we && (rf_waddr != '0) && (rf_waddr == rt_addr);
`ifdef REGFILE_WB_BYPASS_EN
    raw_stall  = raw_src;
    byp_rs_hit = win_rs;
    byp_rt_hit = win_rt;
    byp_data   = rf_wdata;
`else
    raw_stall  = raw_src || win_rs || win_rt;
`endif
  end

endmodule
